// File: rtl/soc_mem_dp_arb.sv
// -----------------------------------------------------------------------------
// soc_mem_dp_arb
//
// Word-addressed on-chip SRAM bank shared by two valid/ready request ports
// (port 0: core data bus, port 1: instruction fetch). A round-robin arbiter
// grants at most one access per cycle. At the grant edge the array is read
// (read-first) and written under the byte strobes. The response (ready pulse
// with rdata/err) appears LATENCY cycles later. Addresses at or beyond WORDS
// are not written, read as zero and flag err.
//
// Parameters
//   DATA_W   data width in bits (multiple of 8), NB = DATA_W/8 byte lanes
//   WORDS    number of array words
//   ADDR_W   word-address width of each port
//   LATENCY  grant-to-ready latency, 1 or 2
//
// Ports (pN = p0 / p1)
//   clk, rst          clock (rising edge), synchronous active-high reset
//   pN_valid   in     request present, held until pN_ready
//   pN_ready   out    one-cycle response pulse
//   pN_wstrb   in     byte write enables, all-zero = read
//   pN_addr    in     word address
//   pN_wdata   in     write data
//   pN_rdata   out    read data (old contents on writes), held between responses
//   pN_err     out    address out of range, held between responses
// -----------------------------------------------------------------------------
module soc_mem_dp_arb #(
    parameter int DATA_W  = 32,
    parameter int WORDS   = 128,
    parameter int ADDR_W  = 22,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [DATA_W/8-1:0]   p0_wstrb,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [DATA_W/8-1:0]   p1_wstrb,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err
);

    localparam int              NB      = DATA_W / 8;
    localparam int              IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0] WORDS_A = (ADDR_W + 1)'(WORDS);
    localparam bit              DIRECT  = (LATENCY == 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [DATA_W-1:0] mem [WORDS];

    logic [1:0]        st [2];
    logic [1:0]        valid_v;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic [1:0]        ready_v;
    logic              last_p1;

    logic [ADDR_W-1:0] acc_addr;
    logic [NB-1:0]     acc_wstrb;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] cap_rdata [2];
    logic [1:0]        cap_err;
    logic [DATA_W-1:0] out_rdata [2];
    logic [1:0]        out_err;

    assign valid_v = {p1_valid, p0_valid};

    // A port in RESP still has valid high but must not be re-granted.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = (st[i] == S_IDLE) && valid_v[i];
        end
    end

    // Round-robin: on a collision the port not granted most recently wins.
    // last_p1 resets to 1 so port 0 wins the first collision.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (elig == 2'b11) begin
                gnt = last_p1 ? 2'b01 : 2'b10;
            end else begin
                gnt = elig;
            end
        end
    end

    // Access mux: the granted port's request as sampled at the grant edge.
    always_comb begin
        if (gnt[1]) begin
            acc_addr  = p1_addr;
            acc_wstrb = p1_wstrb;
            acc_wdata = p1_wdata;
        end else begin
            acc_addr  = p0_addr;
            acc_wstrb = p0_wstrb;
            acc_wdata = p0_wdata;
        end
    end

    assign in_range = ({1'b0, acc_addr} < WORDS_A);
    assign idx      = acc_addr[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    // Array: byte-lane write at the grant edge. Not reset; a write performed
    // before rst is asserted stays in place.
    always_ff @(posedge clk) begin
        if ((|gnt) && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Grant stage: read-first capture for the LATENCY=2 output stage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                cap_rdata[i] <= rd_word;
                cap_err[i]   <= ~in_range;
            end
        end
    end

    // Per-port state and response registers. Outputs only change when the
    // port enters RESP, so rdata/err hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_p1 <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                st[i]        <= S_IDLE;
                out_rdata[i] <= '0;
                out_err[i]   <= 1'b0;
            end
        end else begin
            if (|gnt) begin
                last_p1 <= gnt[1];
            end
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    S_IDLE:   if (gnt[i]) st[i] <= DIRECT ? S_RESP : S_FLIGHT;
                    S_FLIGHT: st[i] <= S_RESP;
                    default:  st[i] <= S_IDLE;
                endcase

                if (DIRECT) begin
                    if (gnt[i]) begin
                        out_rdata[i] <= rd_word;
                        out_err[i]   <= ~in_range;
                    end
                end else if (st[i] == S_FLIGHT) begin
                    out_rdata[i] <= cap_rdata[i];
                    out_err[i]   <= cap_err[i];
                end
            end
        end
    end

    // ready is masked by rst so a request whose response would coincide with
    // the reset cycle is dropped without a pulse.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready_v[i] = (st[i] == S_RESP) && !rst;
        end
    end

    assign p0_ready = ready_v[0];
    assign p1_ready = ready_v[1];
    assign p0_rdata = out_rdata[0];
    assign p1_rdata = out_rdata[1];
    assign p0_err   = out_err[0];
    assign p1_err   = out_err[1];

endmodule

// File: tb/tb_soc_mem_dp_arb.sv
// -----------------------------------------------------------------------------
// tb_soc_mem_dp_arb
//
// Directed bench for soc_mem_dp_arb. Two instances: LATENCY=1 (index 0) and
// LATENCY=2 (index 1), both 32-bit data, 128 words, 22-bit addresses.
// A vector table drives single requests; hand-written sequences cover port
// collisions, streaming on both ports and reset in the middle of a request.
// -----------------------------------------------------------------------------
module tb_soc_mem_dp_arb;

    localparam int DW = 32;
    localparam int AW = 22;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          valid [2][2];
    logic          ready [2][2];
    logic [NB-1:0] wstrb [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic [DW-1:0] rdata [2][2];
    logic          err   [2][2];

    soc_mem_dp_arb #(.DATA_W(DW), .WORDS(128), .ADDR_W(AW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .p0_valid(valid[0][0]), .p0_ready(ready[0][0]), .p0_wstrb(wstrb[0][0]),
        .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]), .p0_rdata(rdata[0][0]), .p0_err(err[0][0]),
        .p1_valid(valid[0][1]), .p1_ready(ready[0][1]), .p1_wstrb(wstrb[0][1]),
        .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]), .p1_rdata(rdata[0][1]), .p1_err(err[0][1])
    );

    soc_mem_dp_arb #(.DATA_W(DW), .WORDS(128), .ADDR_W(AW), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .p0_valid(valid[1][0]), .p0_ready(ready[1][0]), .p0_wstrb(wstrb[1][0]),
        .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]), .p0_rdata(rdata[1][0]), .p0_err(err[1][0]),
        .p1_valid(valid[1][1]), .p1_ready(ready[1][1]), .p1_wstrb(wstrb[1][1]),
        .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]), .p1_rdata(rdata[1][1]), .p1_err(err[1][1])
    );

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [NB-1:0] wstrb;
        logic [DW-1:0] wdata;
        logic          chk_rd;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t vecs [15];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Issue one request and wait (bounded) for its ready. lat is the number of
    // rising edges from the grant-candidate edge to the ready cycle, -1 on timeout.
    task automatic do_req(input int d, input int p, input logic [AW-1:0] a,
                          input logic [NB-1:0] s, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output logic e, output int lat);
        @(posedge clk); #1;
        addr[d][p]  = a;
        wstrb[d][p] = s;
        wdata[d][p] = wd;
        valid[d][p] = 1'b1;
        lat = -1;
        rd  = '0;
        e   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready[d][p]) begin
                lat = c;
                rd  = rdata[d][p];
                e   = err[d][p];
                break;
            end
        end
        @(posedge clk); #1;
        valid[d][p] = 1'b0;
    endtask

    // Both ports request in the same cycle; the winner responds after L
    // edges, the loser one edge later, and each gets exactly one ready.
    task automatic collide(input int d, input int first, input int L, input string nm);
        int   t [2];
        int   n [2];
        logic r [2];
        t = '{-1, -1};
        n = '{0, 0};
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            addr[d][p]  = AW'(p + 1);
            wstrb[d][p] = '0;
            valid[d][p] = 1'b1;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                r[p] = ready[d][p];
                if (r[p]) begin
                    n[p]++;
                    if (t[p] < 0) t[p] = c;
                end
            end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (r[p]) valid[d][p] = 1'b0;
        end
        chk({nm, "_winner_lat"}, t[first], L);
        chk({nm, "_loser_lat"}, t[1-first], L + 1);
        chk({nm, "_p0_ready_count"}, n[0], 1);
        chk({nm, "_p1_ready_count"}, n[1], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          e;
        int            lat;
        logic          r0, r1, prev0;
        int            nrdy;

        vecs[0]  = '{0, 22'd5,        4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{0, 22'd5,        4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 22'd3,        4'hF, 32'h11223344, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{0, 22'd3,        4'h5, 32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0};
        vecs[4]  = '{0, 22'd3,        4'h0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1, 22'd127,      4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1, 22'd0,        4'hF, 32'h01234567, 1'b0, 32'h0,        1'b0};
        vecs[7]  = '{1, 22'd128,      4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[8]  = '{1, 22'd127,      4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1, 22'd0,        4'h0, 32'h0,        1'b1, 32'h01234567, 1'b0};
        vecs[10] = '{0, 22'd128,      4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
        vecs[11] = '{1, 22'h3FFFFF,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
        vecs[12] = '{0, 22'd133,      4'hF, 32'h0BADF00D, 1'b1, 32'h0,        1'b1};
        vecs[13] = '{0, 22'd5,        4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[14] = '{1, 22'd3,        4'h0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0};

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                valid[d][p] = 1'b0;
                wstrb[d][p] = '0;
                addr[d][p]  = '0;
                wdata[d][p] = '0;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("reset_ready_d%0d_p%0d", d, p), {31'b0, ready[d][p]}, 32'd0);
                chk($sformatf("reset_err_d%0d_p%0d", d, p), {31'b0, err[d][p]}, 32'd0);
                chk($sformatf("reset_rdata_d%0d_p%0d", d, p), rdata[d][p], 32'd0);
            end
        end

        // Vector table on the LATENCY=1 instance
        for (int i = 0; i < 15; i++) begin
            do_req(0, vecs[i].port, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd, e, lat);
            chk($sformatf("vec%0d_lat", i), lat, 1);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
        end
        @(negedge clk);
        chk("p0_rdata_hold", rdata[0][0], 32'hDEADBEEF);
        chk("p0_ready_idle", {31'b0, ready[0][0]}, 32'd0);

        // LATENCY=2 instance
        do_req(1, 0, 22'd5, 4'hF, 32'hDEADBEEF, rd, e, lat);
        chk("l2_write_lat", lat, 2);
        chk("l2_write_err", {31'b0, e}, 32'd0);
        do_req(1, 0, 22'd5, 4'h0, 32'h0, rd, e, lat);
        chk("l2_read_lat", lat, 2);
        chk("l2_read_rdata", rd, 32'hDEADBEEF);
        do_req(1, 1, 22'd200, 4'hF, 32'h12345678, rd, e, lat);
        chk("l2_oor_lat", lat, 2);
        chk("l2_oor_err", {31'b0, e}, 32'd1);
        chk("l2_oor_rdata", rd, 32'd0);
        collide(1, 0, 2, "l2_collide");

        // Collisions on the LATENCY=1 instance, starting from reset priority
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        collide(0, 0, 1, "collide_after_reset");
        do_req(0, 0, 22'd1, 4'h0, 32'h0, rd, e, lat);
        chk("single_p0_lat", lat, 1);
        collide(0, 1, 1, "collide_after_p0");

        // Both ports streaming: exactly one response per cycle, alternating
        @(posedge clk); #1;
        addr[0][0] = 22'd5;   wstrb[0][0] = '0; valid[0][0] = 1'b1;
        addr[0][1] = 22'd127; wstrb[0][1] = '0; valid[0][1] = 1'b1;
        prev0 = 1'b0;
        nrdy  = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            r0 = ready[0][0];
            r1 = ready[0][1];
            if (c >= 1) chk($sformatf("stream_one_ready_c%0d", c), {31'b0, r0 ^ r1}, 32'd1);
            if (c >= 2) chk($sformatf("stream_alternate_c%0d", c), {31'b0, r0}, {31'b0, ~prev0});
            if (r0) chk($sformatf("stream_p0_rdata_c%0d", c), rdata[0][0], 32'hDEADBEEF);
            if (r1) chk($sformatf("stream_p1_rdata_c%0d", c), rdata[0][1], 32'hCAFEF00D);
            nrdy  = nrdy + int'(r0) + int'(r1);
            prev0 = r0;
            @(posedge clk); #1;
        end
        valid[0][0] = 1'b0;
        valid[0][1] = 1'b0;
        chk("stream_ready_total", nrdy, 15);
        repeat (3) @(posedge clk);

        // Reset the cycle after a grant: no ready, write kept, clean restart
        do_req(0, 0, 22'd9, 4'hF, 32'h12345678, rd, e, lat);
        chk("rstseq_prewrite_lat", lat, 1);
        @(posedge clk); #1;
        addr[0][0] = 22'd9; wstrb[0][0] = 4'hF; wdata[0][0] = 32'h55AA55AA; valid[0][0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        valid[0][0] = 1'b0;
        @(negedge clk);
        chk("rstseq_no_ready", {31'b0, ready[0][0]}, 32'd0);
        chk("rstseq_granted_rdata", rdata[0][0], 32'h12345678);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rstseq_ready_p%0d", p), {31'b0, ready[0][p]}, 32'd0);
            chk($sformatf("rstseq_err_p%0d", p), {31'b0, err[0][p]}, 32'd0);
            chk($sformatf("rstseq_rdata_p%0d", p), rdata[0][p], 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstseq_quiet_c%0d", c), {31'b0, ready[0][0]}, 32'd0);
        end
        do_req(0, 0, 22'd9, 4'h0, 32'h0, rd, e, lat);
        chk("rstseq_after_lat", lat, 1);
        chk("rstseq_after_rdata", rd, 32'h55AA55AA);
        chk("rstseq_after_err", {31'b0, e}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/soc_mem_dp_arb.md
# soc_mem_dp_arb

Parametrised on-chip SRAM bank for the SoC with two independent valid/ready request ports (data bus and instruction fetch), sharing one word-addressed array through a round-robin arbiter. It generalises the single-port byte-enabled scratch memory with configurable data width, depth and read latency. It also adds a per-port handshake, out-of-range error reporting and a deterministic reset state. It sits between the core's native memory interface (port 0 data, port 1 fetch) and the bus fabric.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8; byte lanes NB = DATA_W/8
- WORDS, 128, number of array words
- ADDR_W, 22, word-address width of each port
- LATENCY, 1, grant-to-ready latency in cycles; legal values 1 or 2 (2 adds an output register stage)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- p0_valid / p1_valid  in  1  request present; held high until the matching ready
- p0_ready / p1_ready  out  1  one-cycle response pulse; rdata/err valid this cycle
- p0_wstrb / p1_wstrb  in  NB  byte write enables; all-zero = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_rdata / p1_rdata  out  DATA_W  read data (old contents on writes)
- p0_err / p1_err  out  1  address out of range, pulsed with ready

## Operation
- Per-port state: IDLE → INFLIGHT (granted, LATENCY cycles) → RESP (ready high for exactly one cycle) → IDLE.
- A port is eligible when in IDLE with valid=1. A port in RESP is not eligible, even though valid is still high that cycle.
- Arbiter: at most one grant per cycle.
  - Single eligible port is granted immediately.
  - Both eligible: grant goes to the port not granted most recently; pointer favours port 0 after reset.
  - Pointer updates to the granted port on every grant.
- At the grant edge the array is accessed with the latched addr/wstrb/wdata:
  - rdata captures mem[addr] before the write (read-first).
  - Each byte lane i with wstrb[i]=1 writes wdata[8i+7:8i].
- Out of range (addr ≥ WORDS): no array write; rdata = 0; err=1 together with ready.
- Outputs rdata/err hold their last values until the next response on that port. ready is 0 outside RESP.
- Array contents are not cleared by rst and are undefined at power-up.
- Reset mid-operation:
  - All in-flight requests are dropped and no ready is issued for them.
  - A write already performed at a grant edge before rst stays in the array.

## Timing
- Reset values: p0_ready=p1_ready=0, p0_err=p1_err=0, p0_rdata=p1_rdata=0, both ports IDLE, rr pointer → port 0 has priority.
- LATENCY=1: valid seen high at edge T with grant → ready high during cycle T+1.
- LATENCY=2: ready high during cycle T+2.
- Minimum per-port repeat interval is LATENCY+1 cycles; the next grant is possible at the edge ending the RESP cycle +1.
- Losing port waits; it is granted at the next edge where the array is free, at most 1 cycle later.
- Aggregate throughput is one access per cycle when both ports stream.
- Requester changing addr/wdata/wstrb while valid and not yet granted: the values sampled at the grant edge are used.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to addr 5 (wstrb=4'hF), then reads addr 5 → write ready at T+1 with err=0; read returns 0xDEADBEEF; with LATENCY=2 both readies arrive at T+2.
- Byte lanes: write 0x11223344 to addr 3, then wstrb=4'b0101 with 0xAABBCCDD → read gives 0x11BB33DD; the write response's rdata shows 0x11223344 (read-first).
- Both ports valid in the same cycle after reset (p0 addr 1, p1 addr 2) → p0 ready at T+1, p1 ready at T+2. Repeat the collision → p1 first next time (round-robin).
- p1 reads addr WORDS (128) with wstrb=4'hF → ready with err=1, rdata=0; addr 127 is unchanged and addr 0 is not aliased.
- Both ports streaming back-to-back with LATENCY=1 → each port gets ready every 2nd cycle; the array sees exactly one access per cycle; no ready is ever issued twice for one request.
- Assert rst the cycle after p0 is granted → no p0_ready; all outputs 0 next cycle; a new p0 request after rst completes normally.
